fan_pwm_ctrl: RTL and testbench



---
 rtl/fan_pwm_tach.sv | 60 ++++++
 rtl/fan_pwm_ctrl.sv | 113 +++++++++++
 tb/tb_fan_pwm_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fan_pwm_tach.sv
// Per-channel tachometer path: input synchroniser, rising-edge detect,
// saturating window counter and stall flag.
module fan_pwm_tach #(
  parameter int TachWidth = 16
) (
  input  logic                 soc_clk,
  input  logic                 rst_n,
  input  logic                 tach,
  input  logic                 win_strobe,
  input  logic                 cur_nz,
  output logic [TachWidth-1:0] tach_cnt,
  output logic                 stall
);

  localparam logic [TachWidth-1:0] CntMax = {TachWidth{1'b1}};
  localparam logic [TachWidth-1:0] CntOne = TachWidth'(1'b1);

  logic                 sync1_r;
  logic                 sync2_r;
  logic                 prev_r;
  logic                 edge_s;
  logic [TachWidth-1:0] cnt_r;
  logic [TachWidth-1:0] tach_cnt_r;
  logic                 stall_r;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= tach;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  always_comb begin
    edge_s = sync2_r & ~prev_r;
  end

  // An edge landing on the boundary cycle opens the new window at 1.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      tach_cnt_r <= '0;
      stall_r    <= 1'b0;
    end else if (win_strobe) begin
      tach_cnt_r <= cnt_r;
      stall_r    <= cur_nz && (cnt_r == '0);
      cnt_r      <= edge_s ? CntOne : '0;
    end else if (edge_s && (cnt_r != CntMax)) begin
      cnt_r <= cnt_r + CntOne;
    end
  end

  assign tach_cnt = tach_cnt_r;
  assign stall    = stall_r;

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Multi-channel fan controller: shared prescaler and period counter,
// per-channel glitch-free PWM with optional ramp, and tach/stall monitoring.
module fan_pwm_ctrl #(
  parameter int NumChannels   = 2,
  parameter int CntWidth      = 8,
  parameter int PrescaleWidth = 16,
  parameter int TachWidth     = 16,
  parameter int WinPeriods    = 64
) (
  input  logic                            soc_clk,
  input  logic                            rst_n,
  input  logic [PrescaleWidth-1:0]        prescale_i,
  input  logic [NumChannels*CntWidth-1:0] duty_i,
  input  logic [NumChannels-1:0]          duty_valid_i,
  input  logic                            ramp_en_i,
  input  logic [NumChannels-1:0]          tach_i,
  output logic [NumChannels-1:0]          pwm_o,
  output logic [NumChannels*TachWidth-1:0] tach_cnt_o,
  output logic [NumChannels-1:0]          stall_o,
  output logic                            period_start_o
);

  localparam int WinW = (WinPeriods > 1) ? $clog2(WinPeriods) : 1;
  localparam logic [WinW-1:0]          WinLast = WinW'(WinPeriods - 1);
  localparam logic [CntWidth-1:0]      PerLast = {{(CntWidth-1){1'b1}}, 1'b0};
  localparam logic [CntWidth-1:0]      CntOne  = CntWidth'(1'b1);
  localparam logic [PrescaleWidth-1:0] PreOne  = PrescaleWidth'(1'b1);
  localparam logic [WinW-1:0]          WinOne  = WinW'(1'b1);

  logic [PrescaleWidth-1:0] pre_r;
  logic [CntWidth-1:0]      per_r;
  logic [WinW-1:0]          win_r;
  logic [CntWidth-1:0]      target_r [NumChannels];
  logic [CntWidth-1:0]      cur_r    [NumChannels];
  logic [NumChannels-1:0]   pwm_r;
  logic [NumChannels-1:0]   cur_nz_s;
  logic                     period_start_r;
  logic                     tick_s;
  logic                     wrap_s;
  logic                     win_strobe_s;

  // >= rather than == so lowering prescale_i mid-count cannot skip a tick.
  always_comb begin
    tick_s       = (pre_r >= prescale_i);
    wrap_s       = tick_s && (per_r == PerLast);
    win_strobe_s = wrap_s && (win_r == WinLast);
  end

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r          <= '0;
      per_r          <= '0;
      win_r          <= '0;
      period_start_r <= 1'b0;
    end else begin
      pre_r          <= tick_s ? '0 : (pre_r + PreOne);
      period_start_r <= wrap_s;
      if (tick_s) begin
        per_r <= wrap_s ? '0 : (per_r + CntOne);
      end
      if (wrap_s) begin
        win_r <= (win_r == WinLast) ? '0 : (win_r + WinOne);
      end
    end
  end

  // Applied duty only moves at period start, so a pulse is never truncated.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NumChannels; c++) begin
        target_r[c] <= '0;
        cur_r[c]    <= '0;
      end
      pwm_r <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (duty_valid_i[c]) begin
          target_r[c] <= duty_i[c*CntWidth +: CntWidth];
        end
        if (wrap_s) begin
          if (!ramp_en_i) begin
            cur_r[c] <= target_r[c];
          end else if (cur_r[c] < target_r[c]) begin
            cur_r[c] <= cur_r[c] + CntOne;
          end else if (cur_r[c] > target_r[c]) begin
            cur_r[c] <= cur_r[c] - CntOne;
          end
        end
        pwm_r[c] <= (per_r < cur_r[c]);
      end
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_tach
    assign cur_nz_s[c] = (cur_r[c] != '0);

    fan_pwm_tach #(
      .TachWidth (TachWidth)
    ) u_tach (
      .soc_clk    (soc_clk),
      .rst_n      (rst_n),
      .tach       (tach_i[c]),
      .win_strobe (win_strobe_s),
      .cur_nz     (cur_nz_s[c]),
      .tach_cnt   (tach_cnt_o[c*TachWidth +: TachWidth]),
      .stall      (stall_o[c])
    );
  end

  assign pwm_o          = pwm_r;
  assign period_start_o = period_start_r;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Directed bench for fan_pwm_ctrl: PWM duty/period, glitch-free updates,
// ramping, tach window counting, stall detection and async reset.
module tb_fan_pwm_ctrl;

  logic        soc_clk = 1'b0;
  logic        rst_n;
  logic [15:0] prescale;
  logic [15:0] duty;
  logic [1:0]  duty_valid;
  logic        ramp_en;
  logic [1:0]  tach;
  logic [1:0]  pwm;
  logic [31:0] tach_cnt;
  logic [1:0]  stall;
  logic        period_start;

  int checks   = 0;
  int failures = 0;
  int psc;
  int len, hi0, hi1, glitch;
  logic t0;

  fan_pwm_ctrl #(
    .NumChannels   (2),
    .CntWidth      (8),
    .PrescaleWidth (16),
    .TachWidth     (16),
    .WinPeriods    (2)
  ) dut (
    .soc_clk        (soc_clk),
    .rst_n          (rst_n),
    .prescale_i     (prescale),
    .duty_i         (duty),
    .duty_valid_i   (duty_valid),
    .ramp_en_i      (ramp_en),
    .tach_i         (tach),
    .pwm_o          (pwm),
    .tach_cnt_o     (tach_cnt),
    .stall_o        (stall),
    .period_start_o (period_start)
  );

  always #5 soc_clk = ~soc_clk;

  // Period starts seen so far; the 2nd, 4th, ... close a window.
  always @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) psc <= 0;
    else if (period_start) psc <= psc + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps();
    bit seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge soc_clk);
      if (period_start) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("ps_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_boundary();
    for (int k = 0; k < 4; k++) begin
      wait_ps();
      if (psc % 2 == 1) break;
    end
  endtask

  // Called on a period-start negedge; runs one full period, optionally
  // writing channel 0 duty at cycles wr1/wr2.
  task automatic measure(input int wr1, input logic [7:0] v1,
                         input int wr2, input logic [7:0] v2,
                         output int l, output int h0, output int h1, output int g);
    bit seen_low = 1'b0;
    bit done = 1'b0;
    l = 0; h0 = 0; h1 = 0; g = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge soc_clk);
      l = k;
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      if (pwm[0] && seen_low) g++;
      if (!pwm[0]) seen_low = 1'b1;
      duty_valid = 2'b00;
      if (k == wr1) begin duty[7:0] = v1; duty_valid = 2'b01; end
      if (k == wr2) begin duty[7:0] = v2; duty_valid = 2'b01; end
      if (period_start) begin
        done = 1'b1;
        break;
      end
    end
    duty_valid = 2'b00;
    if (!done) check_eq("measure_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    prescale   = 16'd0;
    duty       = 16'd0;
    duty_valid = 2'b00;
    ramp_en    = 1'b0;
    tach       = 2'b00;
    repeat (3) @(negedge soc_clk);
    check_eq("rst_pwm", {62'd0, pwm}, 64'd0);
    check_eq("rst_tach_cnt", {32'd0, tach_cnt}, 64'd0);
    check_eq("rst_stall", {62'd0, stall}, 64'd0);
    check_eq("rst_ps", {63'd0, period_start}, 64'd0);
    rst_n = 1'b1;

    // ch0=128, ch1=0 at prescale 0
    duty = {8'd0, 8'd128};
    duty_valid = 2'b11;
    @(negedge soc_clk);
    duty_valid = 2'b00;
    wait_ps();
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("p0_len", len, 64'd255);
    check_eq("p0_hi0", hi0, 64'd128);
    check_eq("p0_hi1", hi1, 64'd0);

    // Mid-period writes 10 then 20: this period keeps 128, next one is 20
    measure(50, 8'd10, 52, 8'd20, len, hi0, hi1, glitch);
    check_eq("gl_hi0_same", hi0, 64'd128);
    check_eq("gl_contig_a", glitch, 64'd0);
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("gl_hi0_new", hi0, 64'd20);
    check_eq("gl_contig_b", glitch, 64'd0);

    // prescale 3, duty 255 -> 1020-cycle periods, constant high
    prescale = 16'd3;
    duty[7:0] = 8'd255;
    duty_valid = 2'b01;
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("ps3_len_a", len, 64'd1020);
    check_eq("ps3_hi0_a", hi0, 64'd80);
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("ps3_len_b", len, 64'd1020);
    check_eq("ps3_hi0_b", hi0, 64'd1020);
    check_eq("ps3_hi1_b", hi1, 64'd0);

    // Back to prescale 0, clear duty, then ramp 0 -> 5
    prescale = 16'd0;
    duty[7:0] = 8'd0;
    duty_valid = 2'b01;
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("clr_len", len, 64'd255);
    check_eq("clr_hi0", hi0, 64'd255);
    ramp_en = 1'b1;
    duty[7:0] = 8'd5;
    duty_valid = 2'b01;
    measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
    check_eq("ramp_0", hi0, 64'd0);
    for (int k = 1; k <= 6; k++) begin
      measure(-1, 8'd0, -1, 8'd0, len, hi0, hi1, glitch);
      check_eq($sformatf("ramp_%0d", k), hi0, (k < 5) ? k : 5);
    end
    ramp_en = 1'b0;

    // Tach windows of 510 cycles starting at a boundary
    wait_boundary();
    for (int i = 1; i <= 2040; i++) begin
      @(negedge soc_clk);
      if (i == 510 || i == 1020 || i == 1530 || i == 2040)
        check_eq($sformatf("win_ps_%0d", i), {63'd0, period_start}, 64'd1);
      if (i == 510) begin
        check_eq("win_cnt0_7", {48'd0, tach_cnt[15:0]}, 64'd7);
        check_eq("win_cnt1_0", {48'd0, tach_cnt[31:16]}, 64'd0);
        check_eq("win_stall0_a", {63'd0, stall[0]}, 64'd0);
        check_eq("win_stall1_a", {63'd0, stall[1]}, 64'd0);
      end
      if (i == 1020) check_eq("win_cnt0_edge", {48'd0, tach_cnt[15:0]}, 64'd1);
      if (i == 1530) begin
        check_eq("stall_cnt0", {48'd0, tach_cnt[15:0]}, 64'd0);
        check_eq("stall0_set", {63'd0, stall[0]}, 64'd1);
        check_eq("stall1_idle", {63'd0, stall[1]}, 64'd0);
      end
      if (i == 2040) begin
        check_eq("stall0_clr", {63'd0, stall[0]}, 64'd0);
        check_eq("stall_cnt0_d", {48'd0, tach_cnt[15:0]}, 64'd1);
      end
      t0 = (i >= 10 && i < 94 && ((i - 10) % 12) < 6) ||
           (i >= 507 && i < 1100) || (i >= 1600 && i < 1606);
      tach = {1'b0, t0};
      duty_valid = 2'b00;
      if (i == 1021) begin duty[7:0] = 8'd50; duty_valid = 2'b01; end
      if (i == 1531) begin duty[7:0] = 8'd0;  duty_valid = 2'b01; end
    end
    tach = 2'b00;

    // Async reset mid-period with pwm high and a latched tach count
    duty[7:0] = 8'd200;
    duty_valid = 2'b01;
    @(negedge soc_clk);
    duty_valid = 2'b00;
    wait_ps();
    repeat (50) @(negedge soc_clk);
    check_eq("pre_rst_pwm0", {63'd0, pwm[0]}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_pwm", {62'd0, pwm}, 64'd0);
    check_eq("arst_tach_cnt", {32'd0, tach_cnt}, 64'd0);
    check_eq("arst_stall", {62'd0, stall}, 64'd0);
    check_eq("arst_ps", {63'd0, period_start}, 64'd0);
    @(negedge soc_clk);
    rst_n = 1'b1;
    len = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge soc_clk);
      len = k;
      if (pwm != 2'b00) check_eq("post_rst_pwm", {62'd0, pwm}, 64'd0);
      if (period_start) break;
    end
    check_eq("post_rst_first_ps", len, 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
